// File: rtl/ddr_ctrl_aref.sv
// ddr_ctrl_aref: periodic SDRAM auto-refresh generator.
// Requests the bus every CNT_REF_MAX+1 clocks, then issues PRECHARGE-all plus AREF_NUM AUTO REFRESH commands.
module ddr_ctrl_aref #(
    parameter int CNT_REF_MAX = 749,
    parameter int TRP_CLK     = 2,
    parameter int TRFC_CLK    = 7,
    parameter int AREF_NUM    = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end_i,
    input  logic        aref_en_i,
    output logic        aref_req_o,
    output logic [3:0]  aref_cmd_o,
    output logic [1:0]  aref_ba_o,
    output logic [12:0] aref_addr_o,
    output logic        aref_end_o
);
    localparam int RW   = CNT_REF_MAX > 0 ? $clog2(CNT_REF_MAX + 1) : 1;
    localparam int DMAX = TRP_CLK > TRFC_CLK ? TRP_CLK : TRFC_CLK;
    localparam int DW   = $clog2(DMAX + 1);
    localparam int NW   = $clog2(AREF_NUM + 1);
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PCHG = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {S_IDLE, S_PCHG, S_TRP, S_AREF, S_TRFC, S_END} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [NW-1:0] num_q, num_d;
    logic          req_q, req_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          end_q, end_d;
    logic          wrap, accept;

    assign wrap   = init_end_i && ref_cnt_q == RW'(CNT_REF_MAX);
    assign accept = state_q == S_IDLE && req_q && aref_en_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = accept ? S_PCHG : S_IDLE;
            S_PCHG: state_d = S_TRP;
            S_TRP:  state_d = dly_q == DW'(TRP_CLK - 1) ? S_AREF : S_TRP;
            S_AREF: state_d = S_TRFC;
            S_TRFC: state_d = dly_q != DW'(TRFC_CLK - 1) ? S_TRFC : num_q == NW'(AREF_NUM) ? S_END : S_AREF;
            S_END:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        dly_d     = state_d != state_q ? '0 : dly_q + 1'b1;
        num_d     = state_q == S_IDLE ? '0 : num_q + NW'(state_d == S_AREF);
        ref_cnt_d = (!init_end_i || wrap) ? '0 : ref_cnt_q + 1'b1;
        // A wrap while pending leaves the request high; losing init always clears it
        req_d     = !init_end_i ? 1'b0 : wrap ? 1'b1 : accept ? 1'b0 : req_q;
        cmd_d     = state_d == S_PCHG ? CMD_PCHG : state_d == S_AREF ? CMD_AREF : CMD_NOP;
        end_d     = state_d == S_END;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            ref_cnt_q <= '0;
            dly_q     <= '0;
            num_q     <= '0;
            req_q     <= 1'b0;
            cmd_q     <= CMD_NOP;
            end_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_cnt_q <= ref_cnt_d;
            dly_q     <= dly_d;
            num_q     <= num_d;
            req_q     <= req_d;
            cmd_q     <= cmd_d;
            end_q     <= end_d;
        end
    end

    assign aref_req_o  = req_q;
    assign aref_cmd_o  = cmd_q;
    assign aref_end_o  = end_q;
    assign aref_ba_o   = 2'b11;
    assign aref_addr_o = 13'h1fff;
endmodule

// File: tb/tb_ddr_ctrl_aref.sv
// tb_ddr_ctrl_aref: directed checks of refresh request timing and command sequence.
module tb_ddr_ctrl_aref;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        init_end = 1'b0;
    logic        aref_en = 1'b0;
    logic        aref_req;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [12:0] aref_addr;
    logic        aref_end;
    int n_cmp = 0, n_err = 0;
    int cyc = 0, rise_cyc = 0;
    logic req_prev = 1'b0;

    ddr_ctrl_aref #(.CNT_REF_MAX(20)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end_i(init_end), .aref_en_i(aref_en),
        .aref_req_o(aref_req), .aref_cmd_o(aref_cmd), .aref_ba_o(aref_ba),
        .aref_addr_o(aref_addr), .aref_end_o(aref_end)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;
    always @(negedge sys_clk) begin
        if (aref_req && !req_prev) rise_cyc = cyc;
        req_prev = aref_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, aref_req, 0);
        check({tag, "_cmd"}, aref_cmd, 4'b0111);
        check({tag, "_ba"}, aref_ba, 2'b11);
        check({tag, "_addr"}, aref_addr, 13'h1fff);
        check({tag, "_end"}, aref_end, 0);
    endtask

    task automatic wait_req(output int k);
        k = 0;
        while (!aref_req && k < 200) begin
            step();
            k++;
        end
    endtask

    // Expected sequence for default timing: PRECHARGE @0, AUTO REFRESH @3 and @11, end pulse @19
    task automatic run_seq(input int drop_at);
        for (int c = 0; c < 20; c++) begin
            check("seq_cmd", aref_cmd, c == 0 ? 4'b0010 : (c == 3 || c == 11) ? 4'b0001 : 4'b0111);
            check("seq_ba", aref_ba, 2'b11);
            check("seq_addr", aref_addr, 13'h1fff);
            check("seq_end", aref_end, c == 19);
            if (c == drop_at) init_end = 1'b0;
            step();
        end
        check("idle_cmd", aref_cmd, 4'b0111);
        check("idle_end", aref_end, 0);
    endtask

    initial begin
        int k, r1, r2, bad_req, bad_cmd;
        step();
        step();
        check_reset_vals("rst");
        sys_rst_n = 1'b1;
        bad_req = 0;
        bad_cmd = 0;
        for (int i = 0; i < 1000; i++) begin
            aref_en = (i >= 500 && i < 505);
            step();
            if (aref_req) bad_req++;
            if (aref_cmd !== 4'b0111) bad_cmd++;
        end
        check("noinit_req", bad_req, 0);
        check("noinit_cmd", bad_cmd, 0);
        aref_en = 1'b0;

        init_end = 1'b1;
        wait_req(k);
        check("first_req", k, 21);
        r1 = cyc;
        while (cyc < r1 + 2) step();
        aref_en = 1'b1;
        step();
        aref_en = 1'b0;
        check("req_clr1", aref_req, 0);
        run_seq(-1);
        r2 = rise_cyc;
        check("req_period", r2 - r1, 21);
        while (cyc < r2 + 2) step();
        aref_en = 1'b1;
        step();
        aref_en = 1'b0;
        check("req_clr2", aref_req, 0);
        run_seq(-1);

        bad_req = 0;
        for (int i = 0; i < 62; i++) begin
            step();
            if (!aref_req) bad_req++;
        end
        check("req_hold", bad_req, 0);
        aref_en = 1'b1;
        step();
        aref_en = 1'b0;
        check("req_clr3", aref_req, 0);
        run_seq(-1);
        bad_cmd = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (aref_cmd !== 4'b0111) bad_cmd++;
        end
        check("single_seq", bad_cmd, 0);

        sys_rst_n = 1'b0;
        init_end = 1'b0;
        step();
        step();
        sys_rst_n = 1'b1;
        init_end = 1'b1;
        aref_en = 1'b1;
        wait_req(k);
        check("req_en_hi", k, 21);
        step();
        check("req_clr4", aref_req, 0);
        run_seq(-1);
        check("req_b2b", aref_req, 1);
        step();
        check("b2b_pchg", aref_cmd, 4'b0010);
        aref_en = 1'b0;

        for (int i = 0; i < 5; i++) step();
        #3 sys_rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        step();
        step();
        sys_rst_n = 1'b1;
        aref_en = 1'b1;
        k = 0;
        while (aref_cmd !== 4'b0010 && k < 100) begin
            step();
            k++;
        end
        check("restart", k, 22);
        run_seq(2);
        bad_req = 0;
        bad_cmd = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (aref_req) bad_req++;
            if (aref_cmd !== 4'b0111) bad_cmd++;
        end
        check("drop_req", bad_req, 0);
        check("drop_cmd", bad_cmd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
